// File: rtl/lfsr_multi_config.sv
// ----------------------------------------------------------------------------
// lfsr_multi_config
//
// N-bit linear feedback shift register over GF(2) with C transition matrices
// that can be selected at run time. The state can be loaded synchronously. On
// each enabled cycle the selected matrix advances the state by one step. The
// serial output is the state MSB.
//
// In the round-constant generator, config 0 holds the forward matrix
// (encrypt) and config 1 holds its inverse (decrypt). Switching the select in
// the middle of a run reverses the direction of the sequence.
//
// Parameters
//   N         state width in bits (N >= 2)
//   C         number of selectable matrices (C >= 1)
//   MATRICES  packed [C-1:0][0:N-1][0:N-1]; element [c][i][j] is row i,
//             column j of matrix c. Row 0 and column 0 sit on the MSB side.
//
// Ports
//   clk          clock, rising edge
//   arst_n       asynchronous active-low reset, clears the state
//   seq_ld_en_i  synchronous load strobe; takes priority over run_en_i
//   seq_i        value loaded into the state
//   conf_sel_i   one-hot matrix select, sampled on every run cycle
//   run_en_i     advance-state enable
//   outp_o       serial output, equal to state[N-1]
// ----------------------------------------------------------------------------
module lfsr_multi_config #(
    parameter int N = 5,
    parameter int C = 2,
    parameter logic [C-1:0][0:N-1][0:N-1] MATRICES = '0
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         seq_ld_en_i,
    input  logic [N-1:0] seq_i,
    input  logic [C-1:0] conf_sel_i,
    input  logic         run_en_i,
    output logic         outp_o
);

    logic [N-1:0]          state;
    logic [N-1:0]          next_state;
    logic [C-1:0][N-1:0]   products;

    // Row-vector times matrix over GF(2). Each set state bit s[i] XORs row i
    // of the matrix into the result. Bit j of the result is column j.
    function automatic logic [N-1:0] gf2_vec_mat(
        input logic [0:N-1][0:N-1] m,
        input logic [N-1:0]        s
    );
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                r[j] = r[j] ^ (m[i][j] & s[i]);
            end
        end
        return r;
    endfunction

    // All C products are computed in parallel. The select only gates which
    // products reach the next state, so a change of mode costs no extra cycle.
    for (genvar c = 0; c < C; c++) begin : g_cfg
        assign products[c] = gf2_vec_mat(MATRICES[c], state);
    end

    // The gated products are ORed together. An all-zero select therefore
    // gives zero, and a multi-hot select gives the OR of the chosen products.
    always_comb begin
        // NOTE: the default assignment comes first, so that every path through
        // this block drives next_state and no latch is inferred.
        next_state = '0;
        for (int c = 0; c < C; c++) begin
            if (conf_sel_i[c]) begin
                next_state = next_state | products[c];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        // NOTE: non-blocking assignments in clocked logic let every register
        // sample pre-edge values, so ordering inside the block is irrelevant.
        if (!arst_n) begin
            state <= '0;
        end else if (seq_ld_en_i) begin
            state <= seq_i;
        end else if (run_en_i) begin
            state <= next_state;
        end
    end

    assign outp_o = state[N-1];

endmodule

// File: tb/tb_lfsr_multi_config.sv
// ----------------------------------------------------------------------------
// tb_lfsr_multi_config
//
// Directed testbench for lfsr_multi_config with N=5 and C=2.
//   config0 U  = rows {01000,00100,10010,00001,10001}  (forward)
//   config1 UR = rows {00011,10000,01000,00111,00010}  (inverse of U)
//
// The expected states below were derived by hand as s' = s * M over GF(2).
// The register is observed through dut.state and outp_o, one time unit
// after each rising edge.
// ----------------------------------------------------------------------------
module tb_lfsr_multi_config;

    localparam int N = 5;
    localparam int C = 2;
    localparam logic [C-1:0][0:N-1][0:N-1] MATS = {
        25'b00011_10000_01000_00111_00010,   // config 1: UR
        25'b01000_00100_10010_00001_10001    // config 0: U
    };

    logic         clk;
    logic         arst_n;
    logic         seq_ld_en_i;
    logic [N-1:0] seq_i;
    logic [C-1:0] conf_sel_i;
    logic         run_en_i;
    logic         outp_o;

    int checks = 0;
    int errors = 0;

    lfsr_multi_config #(
        .N        (N),
        .C        (C),
        .MATRICES (MATS)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .seq_ld_en_i (seq_ld_en_i),
        .seq_i       (seq_i),
        .conf_sel_i  (conf_sel_i),
        .run_en_i    (run_en_i),
        .outp_o      (outp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] observed,
                         input logic [N-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [N-1:0] v);
        seq_i       = v;
        seq_ld_en_i = 1'b1;
        step();
        seq_ld_en_i = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        run_en_i = 1'b1;
        repeat (n) step();
        run_en_i = 1'b0;
    endtask

    // Forward sequence from 10000 under U, with the matching MSB values.
    logic [N-1:0] fwd_exp [0:8];
    logic         fwd_out [0:8];

    initial begin
        fwd_exp = '{5'b10000, 5'b10001, 5'b10011, 5'b10111, 5'b11110,
                    5'b01100, 5'b11001, 5'b00011, 5'b00110};
        fwd_out = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        arst_n      = 1'b0;
        seq_ld_en_i = 1'b0;
        seq_i       = '0;
        conf_sel_i  = 2'b01;
        run_en_i    = 1'b0;

        // Reset state
        #12;
        check("reset_state", dut.state, 5'b00000);
        check("reset_outp", 5'(outp_o), 5'b00000);
        arst_n = 1'b1;
        step();

        // Load followed by a forward run under U
        conf_sel_i = 2'b01;
        load(5'b10000);
        check("fwd_state_0", dut.state, fwd_exp[0]);
        check("fwd_outp_0", 5'(outp_o), 5'(fwd_out[0]));
        run_en_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("fwd_state_%0d", k), dut.state, fwd_exp[k]);
            check($sformatf("fwd_outp_%0d", k), 5'(outp_o), 5'(fwd_out[k]));
        end
        run_en_i = 1'b0;

        // Period: 31 steps from 10000 return to 10000
        load(5'b10000);
        run_cycles(13);
        check("period_step13", dut.state, 5'b11111);
        run_cycles(17);
        check("period_step30", dut.state, 5'b01000);
        check("period_outp30", 5'(outp_o), 5'b00000);
        run_cycles(1);
        check("period_step31", dut.state, 5'b10000);

        // Asynchronous reset asserted mid-run clears the state at once
        run_en_i = 1'b1;
        step();
        step();
        #3;
        arst_n = 1'b0;
        #1;
        check("midrun_reset_state", dut.state, 5'b00000);
        check("midrun_reset_outp", 5'(outp_o), 5'b00000);
        step();
        #2;
        arst_n = 1'b1;
        // With no load, the zero state is a fixed point
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("post_reset_outp_%0d", k), 5'(outp_o), 5'b00000);
        end
        check("post_reset_state", dut.state, 5'b00000);
        run_en_i = 1'b0;

        // Reverse: one UR step from 11001 gives 01100
        conf_sel_i = 2'b10;
        load(5'b11001);
        run_cycles(1);
        check("reverse_one", dut.state, 5'b01100);

        // 62 forward steps and then 62 reverse steps restore the start state
        conf_sel_i = 2'b01;
        load(5'b01011);
        run_cycles(1);
        check("fwd_from_01011", dut.state, 5'b10110);
        run_cycles(61);
        check("fwd_62", dut.state, 5'b01011);
        conf_sel_i = 2'b10;
        run_cycles(1);
        check("rev_from_01011", dut.state, 5'b00101);
        run_cycles(61);
        check("rev_62_restored", dut.state, 5'b01011);

        // A load wins over a run in the same cycle
        conf_sel_i = 2'b01;
        load(5'b10000);
        seq_i       = 5'b01011;
        seq_ld_en_i = 1'b1;
        run_en_i    = 1'b1;
        step();
        seq_ld_en_i = 1'b0;
        run_en_i    = 1'b0;
        check("load_priority", dut.state, 5'b01011);

        // Hold: with neither strobe set, the state does not change
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("hold_state_%0d", k), dut.state, 5'b01011);
        end
        check("hold_outp", 5'(outp_o), 5'b00000);

        // An empty select while running gives a zero state, which then stays 0
        conf_sel_i = 2'b00;
        run_cycles(1);
        check("empty_select", dut.state, 5'b00000);
        conf_sel_i = 2'b01;
        run_cycles(3);
        check("zero_fixed_point", dut.state, 5'b00000);

        // A multi-hot select gives the OR of both products (10001 | 01000)
        load(5'b10000);
        conf_sel_i = 2'b11;
        run_cycles(1);
        check("multi_hot", dut.state, 5'b11001);
        check("multi_hot_outp", 5'(outp_o), 5'b00001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
